// File: rtl/mux_sel_arbiter_pkg.sv
// Shared constants and FSM encoding for the 4-source round-robin mux-select arbiter.
package mux_sel_arbiter_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

endpackage

// File: rtl/mux_sel_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod 4.
module rr_pick4
  import mux_sel_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [SEL_W-1:0]   idx_o,
  output logic               any_o
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    any_o = |req_i;
    idx_o = ptr_i;
    cand  = '0;
    // Walk from the farthest offset down so the closest requester to ptr wins last.
    for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
      cand = ptr_i + SEL_W'(k);
      if (req_i[cand]) begin
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter producing a registered, glitch-free select code for a 4:1 mux,
// with forced rotation after MAX_HOLD cycles and a one-cycle bubble between grants.
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               rel,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_SRC-1:0] gnt,
  output logic               busy,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic [SEL_W-1:0]   win_idx;
  logic               win_any;
  logic               owner_req;
  logic               at_limit;

  rr_pick4 u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // sel_q doubles as the owner index while in StGrant.
  assign owner_req = req[sel_q];
  assign at_limit  = (cnt_q == HoldLast);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (win_any) begin
          state_d        = StGrant;
          sel_d          = win_idx;
          gnt_d[win_idx] = 1'b1;
          busy_d         = 1'b1;
          cnt_d          = '0;
        end
      end
      StGrant: begin
        if (rel || !owner_req || at_limit) begin
          state_d   = StIdle;
          gnt_d     = '0;
          busy_d    = 1'b0;
          ptr_d     = sel_q + 1'b1;
          // Release takes precedence over the hold limit.
          timeout_d = at_limit && !rel && owner_req;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed table, corner sequences, random vs model.
module tb_mux_sel_arbiter;

  localparam int MaxHold = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       rel = 1'b0;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural reference state.
  int         m_owner;
  int         m_held;
  int         m_ptr;
  logic [3:0] e_gnt;
  logic [1:0] e_sel;
  logic       e_busy;
  logic       e_to;

  typedef struct packed {
    logic [3:0] req;
    logic       rel;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl [13];

  mux_sel_arbiter #(
    .MAX_HOLD (MaxHold)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .rel     (rel),
    .sel     (sel),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    e_gnt   = '0;
    e_sel   = '0;
    e_busy  = 1'b0;
    e_to    = 1'b0;
  endtask

  // One rising edge of the arbitration rules, using the inputs currently applied.
  task automatic model_step();
    bit found;
    int w;
    e_to = 1'b0;
    if (m_owner < 0) begin
      found = 0;
      w = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && req[(m_ptr + k) % 4]) begin
          found = 1;
          w = (m_ptr + k) % 4;
        end
      end
      if (found) begin
        m_owner = w;
        m_held  = 1;
        e_gnt   = 4'(1 << w);
        e_sel   = 2'(w);
        e_busy  = 1'b1;
      end else begin
        e_gnt  = '0;
        e_busy = 1'b0;
      end
    end else begin
      if (rel || !req[m_owner] || m_held == MaxHold) begin
        e_to    = !rel && req[m_owner] && (m_held == MaxHold);
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        e_gnt   = '0;
        e_busy  = 1'b0;
      end else begin
        m_held++;
      end
    end
  endtask

  // Apply inputs at a falling edge, clock once, return at the next falling edge.
  task automatic cyc(input logic [3:0] r, input logic l);
    req = r;
    rel = l;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = '0;
    rel   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string name, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic t);
    chk({name, ".gnt"}, {4'b0, gnt}, {4'b0, g});
    chk({name, ".sel"}, {6'b0, sel}, {6'b0, s});
    chk({name, ".busy"}, {7'b0, busy}, {7'b0, b});
    chk({name, ".timeout"}, {7'b0, timeout}, {7'b0, t});
  endtask

  initial begin
    logic [3:0] r;
    logic       l;

    // Round-robin sequence: rel after 2 grant cycles, bubble between grants.
    tbl[0]  = '{4'hF, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{4'hF, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{4'hF, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[4]  = '{4'hF, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[5]  = '{4'hF, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    tbl[6]  = '{4'hF, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[7]  = '{4'hF, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[8]  = '{4'hF, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[9]  = '{4'hF, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[10] = '{4'hF, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[11] = '{4'hF, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
    tbl[12] = '{4'hF, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};

    model_reset();
    #2;
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    do_reset();

    // Single request, one-cycle latency.
    cyc(4'b0100, 1'b0);
    chk_out("single_req", 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0);
    chk_out("drop_single", 4'b0000, 2'd2, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0);
    chk_out("idle_sel_hold", 4'b0000, 2'd2, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].req, tbl[i].rel);
      chk_out($sformatf("rr_row%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].busy, tbl[i].to);
    end

    // Hold limit: 8 grant cycles, timeout bubble, regrant.
    do_reset();
    for (int i = 0; i < MaxHold; i++) begin
      cyc(4'b0001, 1'b0);
      chk_out($sformatf("hold_c%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    cyc(4'b0001, 1'b0);
    chk_out("hold_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    cyc(4'b0001, 1'b0);
    chk_out("hold_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Release coincident with hold limit: no timeout.
    do_reset();
    for (int i = 0; i < MaxHold; i++) cyc(4'b0001, 1'b0);
    cyc(4'b0001, 1'b1);
    chk_out("rel_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Owner 1 drops its request while 3 waits; non-owner changes ignored during grant.
    do_reset();
    cyc(4'b0010, 1'b0);
    chk_out("own1_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc(4'b1011, 1'b0);
    chk_out("own1_nonowner", 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc(4'b1000, 1'b0);
    chk_out("own1_drop", 4'b0000, 2'd1, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0);
    chk_out("own3_grant", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Asynchronous reset during a grant of source 2.
    do_reset();
    cyc(4'b0001, 1'b1);
    cyc(4'b0000, 1'b0);
    cyc(4'b0100, 1'b0);
    chk_out("pre_async", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(4'b0101, 1'b0);
    chk_out("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Random traffic against the model; owner usually keeps requesting to exercise timeouts.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      r = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
      l = ($urandom_range(0, 15) == 0);
      cyc(r, l);
      chk_out($sformatf("rand%0d", i), e_gnt, e_sel, e_busy, e_to);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum number of cycles one grant is held before a forced rotation; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  request lines; req[i] high means source i wants the mux.
REQ-005 rel  input  1  current owner done; release the grant this cycle.
REQ-006 sel  output  2  select code driving the downstream 4:1 mux sel port.
REQ-007 gnt  output  4  one-hot grant; all zero when no owner.
REQ-008 busy  output  1  high while a grant is held.
REQ-009 timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-010 The block SHALL implement two states: IDLE and GRANT; all outputs registered.
REQ-011 IDLE: if req != 0, the winner SHALL be the first set req bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); the next cycle is GRANT with gnt one-hot on the winner, sel = winner index, busy = 1.
REQ-012 Latency from req assertion in IDLE to gnt/sel valid SHALL be exactly 1 cycle.
REQ-013 IDLE with req == 0: stay in IDLE, gnt = 0, busy = 0, sel holds the last granted index.
REQ-014 GRANT: hold counter SHALL start at 0 on grant entry and increment by 1 each GRANT cycle.
REQ-015 GRANT exit conditions: rel = 1; or req[owner] = 0; or counter = MAX_HOLD-1. Any of these SHALL return to IDLE on the next edge.
REQ-016 On exit, ptr SHALL become (owner+1) mod 4, so the previous owner has lowest priority on the next arbitration.
REQ-017 The cycle after exit SHALL be an IDLE cycle with gnt = 0 (one-cycle bubble); there is no back-to-back grant.
REQ-018 timeout SHALL pulse for one cycle, coincident with the IDLE bubble, only when the exit cause is counter = MAX_HOLD-1 and rel = 0 and req[owner] = 1 in that cycle.
REQ-019 Simultaneous rel and counter limit: treated as release; no timeout pulse.
REQ-020 Changes on non-owner req bits during GRANT SHALL have no effect until IDLE.
REQ-021 sel SHALL change only on entry to GRANT, so the downstream mux output is glitch-free across the bubble.
REQ-022 Hold counter width SHALL be 8 bits; it never exceeds MAX_HOLD-1.

Reset
REQ-023 rst_n low SHALL immediately force state = IDLE, gnt = 4'b0000, sel = 2'b00, busy = 0, timeout = 0, ptr = 0, counter = 0.
REQ-024 Reset asserted mid-grant SHALL drop the grant without a timeout pulse; after release, the first arbitration uses ptr = 0.
REQ-025 Reset deassertion is synchronised externally; the first arbitration SHALL be at the first rising edge with rst_n high.

Structure
REQ-026 A shared package SHALL hold NUM_SRC = 4, SEL_W = 2, and the IDLE/GRANT state encoding.
REQ-027 One sub-module, rr_pick4, SHALL be purely combinational.
REQ-028 rr_pick4 SHALL take req and ptr and return the winner index plus an any-request flag.
REQ-029 The top SHALL hold the FSM, ptr, counter and output registers.

Verification
REQ-030 Reset, then req = 4'b0100 -> one cycle later gnt = 4'b0100, sel = 2'b10, busy = 1.
REQ-031 req = 4'b1111, rel pulsed after 2 GRANT cycles, repeated -> grant order 0, 1, 2, 3, 0, with a gnt = 0 bubble between each.
REQ-032 req = 4'b0001 held, rel = 0, MAX_HOLD = 8 -> gnt held 8 cycles, then timeout = 1 for one cycle with gnt = 0, then source 0 regranted.
REQ-033 Owner 1 drops req[1] mid-grant while req[3] = 1 -> IDLE bubble, then gnt = 4'b1000, sel = 2'b11.
REQ-034 rel = 1 in the same cycle as counter = 7 (MAX_HOLD = 8) -> exit with timeout = 0.
REQ-035 rst_n pulsed low during a grant of source 2 -> outputs zero asynchronously; after release, req = 4'b0101 -> source 0 granted.
